// File: rtl/display_pkg.sv
// Shared types and helpers for the display scan-out engine.
package display_pkg;

    // Scan-out sequencing: serialise a row/plane, latch it, then light it.
    typedef enum logic [1:0] {
        SHIFT   = 2'd0,
        LATCH   = 2'd1,
        DISPLAY = 2'd2
    } state_t;

    // Pixel layout is {R,G,B}, each width/3 bits; blue starts at bit 0.
    function automatic int r_lsb(input int width);
        return width - width / 3;
    endfunction

    function automatic int g_lsb(input int width);
        return width / 3;
    endfunction

    // Binary-weighted on-time of bit-plane b.
    function automatic int plane_time(input int base, input int b);
        return base << b;
    endfunction

endpackage

// File: rtl/bcm_plane_timer.sv
// Counts the output-enable time of one bit-plane after a start pulse.
module bcm_plane_timer
    import display_pkg::*;
#(
    parameter int planes    = 8,
    parameter int base_time = 4,
    parameter int BW        = 3,
    parameter int TW        = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [BW-1:0] plane,
    output logic          done
);

    logic [TW-1:0] cnt;
    logic          busy;

    // Load plane_time-1 on start; done is high in the final counted cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            cnt  <= TW'(plane_time(base_time, int'(plane)) - 1);
            busy <= 1'b1;
        end else if (busy) begin
            if (cnt == '0) begin
                busy <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Terminal count of an armed timer.
    always_comb begin
        done = busy && (cnt == '0);
    end

endmodule

// File: rtl/display_scanout.sv
// HUB75 scan-out: fetches pixels, shifts one bit-plane per pass, latches,
// then enables the panel for a binary-weighted time. Owns the bank select.
module display_scanout
    import display_pkg::*;
#(
    parameter int segments  = 1,
    parameter int rows      = 8,
    parameter int columns   = 32,
    parameter int width     = 24,
    parameter int base_time = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [$clog2(rows)-1:0]     rrow,
    output logic [$clog2(columns)-1:0]  rcol,
    input  logic [width*segments-1:0]   rdata,
    output logic                        flip,
    input  logic                        swap_req,
    output logic                        swap_ack,
    output logic                        frame_done,
    output logic [3*segments-1:0]       panel_rgb,
    output logic                        panel_clk,
    output logic                        panel_lat,
    output logic                        panel_oe,
    output logic [$clog2(rows)-1:0]     panel_addr
);

    localparam int P      = width / 3;
    localparam int RW     = $clog2(rows);
    localparam int CW     = $clog2(columns);
    localparam int BW     = $clog2(P);
    localparam int KW     = $clog2(2 * columns + 2);
    localparam int TW     = $clog2(base_time) + P;
    localparam int R_LSB  = r_lsb(width);
    localparam int G_LSB  = g_lsb(width);
    localparam logic [KW-1:0] K_LAST = KW'(2 * columns + 1);
    localparam logic [KW-1:0] K_PIX  = KW'(2 * columns);

    state_t           state, state_nxt;
    logic [RW-1:0]    r;
    logic [BW-1:0]    b;
    logic [KW-1:0]    k;
    logic [3*segments-1:0] rgb_nxt;
    logic             tmr_done;

    bcm_plane_timer #(
        .planes    (P),
        .base_time (base_time),
        .BW        (BW),
        .TW        (TW)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .start (state == LATCH),
        .plane (b),
        .done  (tmr_done)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SHIFT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: shift a full row, latch for one cycle, display until the timer expires.
    always_comb begin
        state_nxt = state;
        case (state)
            SHIFT:   if (k == K_LAST) state_nxt = LATCH;
            LATCH:   state_nxt = DISPLAY;
            DISPLAY: if (tmr_done) state_nxt = SHIFT;
            default: state_nxt = SHIFT;
        endcase
    end

    // FSM outputs; a pixel is read at even k and clocked into the panel two cycles later.
    always_comb begin
        rrow       = r;
        rcol       = CW'(k >> 1);
        panel_clk  = (state == SHIFT) && k[0] && (k >= KW'(3));
        panel_lat  = (state == LATCH);
        panel_oe   = (state != DISPLAY);
        frame_done = (state == DISPLAY) && tmr_done &&
                     (b == BW'(P - 1)) && (r == RW'(rows - 1));
    end

    // Select bit b of each colour of each segment from the fetched pixel.
    always_comb begin
        rgb_nxt = '0;
        for (int s = 0; s < segments; s++) begin
            rgb_nxt[3*s+2] = rdata[width*s + R_LSB + int'(b)];
            rgb_nxt[3*s+1] = rdata[width*s + G_LSB + int'(b)];
            rgb_nxt[3*s]   = rdata[width*s + int'(b)];
        end
    end

    // Column phase, pixel register, panel address and row/plane counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k          <= '0;
            r          <= '0;
            b          <= '0;
            panel_rgb  <= '0;
            panel_addr <= '0;
        end else begin
            case (state)
                SHIFT: begin
                    k <= (k == K_LAST) ? '0 : k + 1'b1;
                    if (k[0] && (k < K_PIX)) begin
                        panel_rgb <= rgb_nxt;
                    end
                end
                LATCH: begin
                    panel_addr <= r;
                end
                DISPLAY: begin
                    if (tmr_done) begin
                        if (b == BW'(P - 1)) begin
                            b <= '0;
                            r <= (r == RW'(rows - 1)) ? '0 : r + 1'b1;
                        end else begin
                            b <= b + 1'b1;
                        end
                    end
                end
                default: k <= '0;
            endcase
        end
    end

    // Bank swap only at the frame boundary, acknowledged as flip changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flip     <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            swap_ack <= frame_done && swap_req;
            if (frame_done && swap_req) begin
                flip <= ~flip;
            end
        end
    end

endmodule

// File: tb/tb_display_scanout.sv
// Directed bench for display_scanout: reset, bit-plane extraction, BCM timing,
// frame sequencing, bank swap handshake and reset in the middle of a plane.
module tb_display_scanout;

    localparam logic [23:0] PAT0 = 24'hA5_3C_0F;
    localparam logic [23:0] PAT1 = 24'h5A_C3_F0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  rrow;
    logic [4:0]  rcol;
    logic [23:0] rdata = '0;
    logic        flip;
    logic        swap_req = 1'b0;
    logic        swap_ack;
    logic        frame_done;
    logic [2:0]  panel_rgb;
    logic        panel_clk;
    logic        panel_lat;
    logic        panel_oe;
    logic [2:0]  panel_addr;

    int errors = 0;
    int checks = 0;
    int t = 0;
    int req_at = -1;
    int fd_q[$];
    int ack_q[$];
    int flip_q[$];
    logic prev_flip = 1'b0;

    display_scanout dut (
        .clk        (clk),
        .rst        (rst),
        .rrow       (rrow),
        .rcol       (rcol),
        .rdata      (rdata),
        .flip       (flip),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .frame_done (frame_done),
        .panel_rgb  (panel_rgb),
        .panel_clk  (panel_clk),
        .panel_lat  (panel_lat),
        .panel_oe   (panel_oe),
        .panel_addr (panel_addr)
    );

    // Clock.
    always #5 clk = ~clk;

    // Bench memory: one constant pattern per bank, one-cycle read latency.
    always @(posedge clk) rdata <= flip ? PAT1 : PAT0;

    function automatic logic [2:0] exp_bits(input logic [23:0] p, input int b);
        return {p[16+b], p[8+b], p[b]};
    endfunction

    task automatic do_release();
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        t = 0;
    endtask

    // Walks one SHIFT/LATCH/DISPLAY pass starting at its first SHIFT sample and
    // returns on the first SHIFT sample of the following pass.
    task automatic run_plane(input int row, input int pl, input logic [2:0] exp_rgb, input int exp_oe);
        int n = 0;
        int pulses = 0;
        int oe_w = 0;
        int lat_w = 0;
        bit fin = 0;
        logic [2:0] prev_rgb;
        logic [2:0] prev_addr;
        logic prev_lat = 1'b0;
        prev_rgb  = panel_rgb;
        prev_addr = panel_addr;
        checks++;
        if (panel_oe !== 1'b1 || rrow !== 3'(row) || rcol !== 5'd0) begin
            errors++;
            $display("FAIL shift_entry r%0d b%0d: oe=%b rrow=%0d rcol=%0d, want oe=1 rrow=%0d rcol=0",
                     row, pl, panel_oe, rrow, rcol, row);
        end
        while (!fin) begin
            if (oe_w > 0 && panel_oe === 1'b1) begin
                fin = 1;
            end else if (n >= 1200) begin
                errors++;
                $display("FAIL plane_timeout r%0d b%0d: no end of display after %0d cycles", row, pl, n);
                fin = 1;
            end else begin
                if (t == req_at) swap_req = 1'b1;
                if (frame_done === 1'b1) fd_q.push_back(t);
                if (swap_ack === 1'b1) begin
                    ack_q.push_back(t);
                    swap_req = 1'b0;
                end
                if (flip !== prev_flip) begin
                    flip_q.push_back(t);
                    prev_flip = flip;
                end
                if (n == 2 || n == 62) begin
                    checks++;
                    if (rcol !== 5'(n / 2)) begin
                        errors++;
                        $display("FAIL rcol_seq r%0d b%0d k%0d: got %0d want %0d", row, pl, n, rcol, n / 2);
                    end
                end
                if (panel_clk === 1'b1) begin
                    pulses++;
                    checks++;
                    if (panel_rgb !== exp_rgb || panel_rgb !== prev_rgb) begin
                        errors++;
                        $display("FAIL pixel_bits r%0d b%0d k%0d: got %b (prev %b) want stable %b",
                                 row, pl, n, panel_rgb, prev_rgb, exp_rgb);
                    end
                end
                if (panel_lat === 1'b1) lat_w++;
                if (panel_oe === 1'b0) begin
                    if (oe_w == 0) begin
                        checks++;
                        if (prev_lat !== 1'b1 || panel_addr !== 3'(row)) begin
                            errors++;
                            $display("FAIL latch_then_enable r%0d b%0d: prev_lat=%b addr=%0d want 1,%0d",
                                     row, pl, prev_lat, panel_addr, row);
                        end
                    end
                    oe_w++;
                end
                if (panel_addr !== prev_addr) begin
                    checks++;
                    if (prev_lat !== 1'b1) begin
                        errors++;
                        $display("FAIL addr_outside_latch r%0d b%0d: addr %0d->%0d", row, pl, prev_addr, panel_addr);
                    end
                end
                prev_rgb  = panel_rgb;
                prev_lat  = panel_lat;
                prev_addr = panel_addr;
                n++;
                t++;
                @(negedge clk);
            end
        end
        checks++;
        if (pulses != 32) begin
            errors++;
            $display("FAIL clk_pulses r%0d b%0d: got %0d want 32", row, pl, pulses);
        end
        checks++;
        if (lat_w != 1) begin
            errors++;
            $display("FAIL lat_width r%0d b%0d: got %0d want 1", row, pl, lat_w);
        end
        checks++;
        if (oe_w != exp_oe) begin
            errors++;
            $display("FAIL oe_width r%0d b%0d: got %0d want %0d", row, pl, oe_w, exp_oe);
        end
    endtask

    task automatic run_rows(input int first, input int last, input logic [23:0] pat);
        for (int r = first; r <= last; r++) begin
            for (int b = 0; b < 8; b++) begin
                run_plane(r, b, exp_bits(pat, b), 4 << b);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        swap_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({rrow, rcol, flip, swap_ack, frame_done, panel_rgb, panel_clk, panel_lat, panel_addr} !== '0
                || panel_oe !== 1'b1) begin
                errors++;
                $display("FAIL reset_outputs: rrow=%0d rcol=%0d flip=%b ack=%b fd=%b rgb=%b clk=%b lat=%b addr=%0d oe=%b",
                         rrow, rcol, flip, swap_ack, frame_done, panel_rgb, panel_clk, panel_lat, panel_addr, panel_oe);
            end
        end
        do_release();
    endtask

    task automatic test_bit_extraction();
        run_plane(0, 0, 3'b101, 4);
    endtask

    task automatic test_bcm_durations();
        run_plane(0, 1, 3'b001, 8);
        run_plane(0, 2, 3'b111, 16);
        run_plane(0, 3, 3'b011, 32);
        run_plane(0, 4, 3'b010, 64);
        run_plane(0, 5, 3'b110, 128);
        run_plane(0, 6, 3'b000, 256);
        run_plane(0, 7, 3'b100, 512);
    endtask

    task automatic test_frame_and_swap();
        req_at = 5000;
        run_rows(1, 7, PAT0);
        req_at = -1;
        checks++;
        if (fd_q.size() != 1 || fd_q[0] != 12447) begin
            errors++;
            $display("FAIL frame_done_first: count=%0d at=%0d want 1 at 12447",
                     fd_q.size(), (fd_q.size() > 0) ? fd_q[0] : -1);
        end
        checks++;
        if (flip_q.size() != 0) begin
            errors++;
            $display("FAIL flip_mid_frame: flip changed at t=%0d, want no change before 12448", flip_q[0]);
        end
        checks++;
        if (flip !== 1'b1 || swap_ack !== 1'b1 || t != 12448) begin
            errors++;
            $display("FAIL swap_at_boundary t=%0d: flip=%b ack=%b want 1,1 at 12448", t, flip, swap_ack);
        end
    endtask

    task automatic test_swap_hold();
        run_rows(0, 7, PAT1);
        checks++;
        if (fd_q.size() != 2 || fd_q[1] != 24895) begin
            errors++;
            $display("FAIL frame_done_period: count=%0d last=%0d want 2, 24895",
                     fd_q.size(), (fd_q.size() > 0) ? fd_q[fd_q.size()-1] : -1);
        end
        checks++;
        if (ack_q.size() != 1 || ack_q[0] != 12448) begin
            errors++;
            $display("FAIL swap_ack_once: count=%0d first=%0d want 1 at 12448",
                     ack_q.size(), (ack_q.size() > 0) ? ack_q[0] : -1);
        end
        checks++;
        if (flip_q.size() != 1 || flip !== 1'b1 || swap_req !== 1'b0) begin
            errors++;
            $display("FAIL flip_held: changes=%0d flip=%b req=%b want 1 change, flip=1, req=0",
                     flip_q.size(), flip, swap_req);
        end
    endtask

    task automatic test_reset_mid_display();
        int w = 0;
        for (int b = 0; b < 5; b++) begin
            run_plane(0, b, exp_bits(PAT1, b), 4 << b);
        end
        while (panel_oe !== 1'b0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (panel_oe !== 1'b0) begin
            errors++;
            $display("FAIL plane5_display: oe=%b after %0d cycles want 0", panel_oe, w);
        end
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (panel_oe !== 1'b1 || flip !== 1'b0 || swap_ack !== 1'b0 || frame_done !== 1'b0
            || panel_lat !== 1'b0 || panel_clk !== 1'b0 || panel_rgb !== 3'b000 || panel_addr !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: oe=%b flip=%b ack=%b fd=%b lat=%b clk=%b rgb=%b addr=%0d want 1,0,0,0,0,0,000,0",
                     panel_oe, flip, swap_ack, frame_done, panel_lat, panel_clk, panel_rgb, panel_addr);
        end
        repeat (2) @(negedge clk);
        prev_flip = 1'b0;
        do_release();
        run_plane(0, 0, 3'b101, 4);
        run_plane(0, 1, 3'b001, 8);
    endtask

    initial begin
        test_reset();
        test_bit_extraction();
        test_bcm_durations();
        test_frame_and_swap();
        test_swap_hold();
        test_reset_mid_display();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scanout.md
# display_scanout

Scan-out engine reading the double-buffered display memory and driving a HUB75-style LED panel. Walks every scan row and every colour bit-plane, and fetches pixels through the memory read port (`rrow`/`rcol`, 1-cycle read latency). Serialises one bit per colour per segment, latches, then enables output for a binary-weighted time (BCM). Owns the `flip` bank select and swaps banks only at frame boundaries, on request from the frame writer.

## Interface
- `segments`, 1: panel segments driven in parallel; must match the memory.
- `rows`, 8: scan rows per segment.
- `columns`, 32: pixels per row.
- `width`, 24: bits per pixel per segment, `{R,G,B}` with `width/3` bits each.
- `base_time`, 4: output-enable cycles for bit-plane 0.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `rrow`, out, `$clog2(rows)`: memory read row.
- `rcol`, out, `$clog2(columns)`: memory read column.
- `rdata`, in, `width*segments`: memory read data, valid one cycle after `rrow`/`rcol`.
- `flip`, out, 1: bank currently displayed; writer writes `!flip`.
- `swap_req`, in, 1: level; writer has finished bank `!flip`.
- `swap_ack`, out, 1: one-cycle pulse when `flip` toggles.
- `frame_done`, out, 1: one-cycle pulse at the end of each frame.
- `panel_rgb`, out, `3*segments`: segment s at `[3s+:3]`, `{r,g,b}`.
- `panel_clk`, out, 1: panel shift clock; data is sampled on its rising edge.
- `panel_lat`, out, 1: latch strobe, high for one cycle.
- `panel_oe`, out, 1: active-low output enable; 1 = blanked.
- `panel_addr`, out, `$clog2(rows)`: row address driven to the panel.

## Operation
- Plane count is P = width/3. Segment s pixel is `rdata[width*s +: width]`, with R = `[width-1 -: P]`, G = `[2P-1 -: P]`, B = `[P-1:0]`.
- FSM states are SHIFT, LATCH and DISPLAY. Counters are row r (0..rows-1), plane b (0..P-1) and column c.
- **SHIFT:** for each c, drive `rrow`=r and `rcol`=c. Bit b of R/G/B of each segment is registered into `panel_rgb`. `panel_clk` pulses once per pixel. `panel_oe`=1 throughout.
- **LATCH:** one cycle with `panel_lat`=1, `panel_oe`=1, and `panel_addr`<=r.
- **DISPLAY:** `panel_oe`=0 for exactly `base_time << b` cycles.
- **Sequencing after DISPLAY:**
  - b increments; when b wraps P-1 to 0, r increments.
  - When r wraps rows-1 to 0, the frame ends.
  - The FSM then returns to SHIFT.
- **Frame end:** pulse `frame_done` in the last DISPLAY cycle. If `swap_req`=1 in that same cycle, `flip` toggles and `swap_ack` pulses in the next cycle.
- **Bank stability:** `flip` never changes mid-frame. `swap_req` asserted mid-frame is held off until the frame boundary. The writer must hold `swap_req` until it sees `swap_ack`, then drop it.
- **Sizing:** all counters are sized by `$clog2`; shift durations are computed at width `$clog2(base_time)+P`.

## Timing
- Reset values:
  - All outputs are 0, except `panel_oe`=1.
  - Internal state is SHIFT with r=b=c=0; `flip`=0.
  - SHIFT starts on the first edge after `rst` falls.
- SHIFT cycle numbering, with k=0 at state entry:
  - `rcol`=c is driven in cycle 2c.
  - `rdata` is valid in cycle 2c+1.
  - `panel_rgb` holds pixel c in cycles 2c+2 and 2c+3.
  - `panel_clk`=1 in cycle 2c+3 only.
  - SHIFT lasts 2·columns+2 cycles.
- LATCH is 1 cycle. DISPLAY is `base_time<<b` cycles.
- Default frame length:
  - Per row: 8·(66+1) + 4·255 = 1556 cycles.
  - Per frame: 8 rows × 1556 = 12448 cycles.
- `rst` mid-operation immediately forces the reset values: the panel blanks and `flip` returns to 0. No `swap_ack` or `frame_done` is emitted.

## Structure
- Package `display_pkg` holds:
  - the state enum (SHIFT/LATCH/DISPLAY);
  - colour field offset functions of `width`;
  - the `plane_time(b)` function.
- One sub-module, `bcm_plane_timer`, takes b and a start pulse, counts `base_time<<b` cycles, and asserts done.
- The top level owns the FSM, counters, pixel pipeline and flip logic.

## Test plan
1. **Reset state:** hold `rst` for 3 cycles. Required: `panel_oe`=1, `flip`=0 and all other outputs 0; the first `rcol`=0 appears in the cycle after `rst` falls.
2. **Bit extraction:** bench memory returns `rdata`=24'hA5_3C_0F at every column. Required:
   - Plane 0 presents `panel_rgb`=3'b101 for every pixel.
   - Plane 7 presents `panel_rgb`=3'b100.
   - Each plane has 32 `panel_clk` pulses, each rising while `panel_rgb` is stable.
3. **BCM durations:** measure the `panel_oe` low width. Required: 4 cycles for plane 0 and 512 cycles for plane 7; `panel_lat` is one cycle and precedes each enable; `panel_addr` changes only during LATCH.
4. **Row wrap and frame length:** run a full frame. Required: rows visited 0..7 in order, `frame_done` exactly every 12448 cycles, `panel_addr` returning to 0.
5. **Swap handshake:** raise `swap_req` at cycle 5000.
   - Required: `flip` unchanged until the frame boundary; it then toggles to 1, `swap_ack` pulses once, and `rrow`/`rcol` reads continue with `flip`=1.
   - With `swap_req` low at the next boundary, `flip` is held.
6. **Reset mid-DISPLAY of plane 5:** assert `rst`. Required: `panel_oe`=1 and `flip`=0 immediately; after release, SHIFT restarts at row 0, plane 0.
